// File: rtl/frodo_mac_stream.sv
// frodo_mac_stream: streaming FrodoKEM secret multiply-accumulate with
// cmd/in/out valid-ready; vector (acc += S*a) and outer (acc_mat + s_col*a).
// Ports: cmd_* command bundle, in_* data beats, out_* results, busy.
module frodo_mac_stream #(
  parameter int A    = 4,
  parameter int S    = 8,
  parameter int SW   = 5,
  parameter int LOGQ = 16,
  parameter int LENW = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_outer,
  input  logic                  cmd_neg,
  input  logic [LENW-1:0]       cmd_len,
  input  logic [16*S-1:0]       cmd_acc_vec,
  input  logic [SW*S-1:0]       cmd_s_col,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*A-1:0]       in_a,
  input  logic [SW*A*S-1:0]     in_s_mat,
  input  logic [16*A*S-1:0]     in_acc_mat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*S-1:0]       out_vec,
  output logic [16*A*S-1:0]     out_mat,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [15:0] QMASK =
    16'((32'd1 << LOGQ) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, stateNext;

  logic            outerMode;
  logic            negMode;
  logic [LENW-1:0] lenReg;
  logic [LENW-1:0] beatCnt;
  logic [15:0]     acc [S];
  logic [15:0]     accNext [S];
  logic [SW-1:0]   sCol [S];
  logic [16*A*S-1:0] resMat;
  logic [16*A*S-1:0] matNext;
  logic            resValid;
  logic            resLast;
  logic            cmdFire;
  logic            inFire;
  logic            lastBeat;

  // Signed-magnitude secret times a, folded mod 2^LOGQ.
  function automatic logic [15:0] term(
    input logic [SW-1:0] s,
    input logic [15:0]   a,
    input logic          neg
  );
    logic [15:0] p;
    p = a * 16'(s[SW-1:1]);
    if (s[0] ^ neg) p = 16'd0 - p;
    return p & QMASK;
  endfunction

  assign cmdFire  = cmd_valid & cmd_ready;
  assign inFire   = in_valid & in_ready;
  assign lastBeat = (beatCnt == lenReg - LENW'(1));

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Outer mode stalls on a full result register unless it drains now.
  assign in_ready = (state == RUN) &
    (~outerMode |
     ((beatCnt < lenReg) & (~resValid | out_ready)));

  assign out_valid = (state == DONE) | resValid;
  assign out_last  = (state == DONE) | (resValid & resLast);
  assign out_mat   = resMat;

  for (genvar g = 0; g < S; g++) begin : gVec
    assign out_vec[16*g+:16] = acc[g];
  end

  always_comb begin
    for (int j = 0; j < S; j++) begin
      accNext[j] = acc[j];
      for (int i = 0; i < A; i++) begin
        accNext[j] = accNext[j] + term(
          in_s_mat[SW*(j*A+i)+:SW],
          in_a[16*i+:16] & QMASK,
          negMode);
      end
      accNext[j] = accNext[j] & QMASK;
    end
  end

  always_comb begin
    matNext = '0;
    for (int j = 0; j < S; j++) begin
      for (int i = 0; i < A; i++) begin
        matNext[16*(j*A+i)+:16] =
          ((in_acc_mat[16*(j*A+i)+:16] & QMASK) +
           term(sCol[j], in_a[16*i+:16] & QMASK,
                negMode)) & QMASK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len != '0)  stateNext = RUN;
          else if (!cmd_outer) stateNext = DONE;
        end
      end
      RUN: begin
        if (!outerMode) begin
          if (inFire && lastBeat) stateNext = DONE;
        end else if (resValid && resLast && out_ready) begin
          stateNext = IDLE;
        end
      end
      DONE: begin
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outerMode <= 1'b0;
      negMode   <= 1'b0;
      lenReg    <= '0;
      beatCnt   <= '0;
      resMat    <= '0;
      resValid  <= 1'b0;
      resLast   <= 1'b0;
      for (int j = 0; j < S; j++) begin
        acc[j]  <= '0;
        sCol[j] <= '0;
      end
    end else begin
      if (cmdFire) begin
        outerMode <= cmd_outer;
        negMode   <= cmd_neg;
        lenReg    <= cmd_len;
        beatCnt   <= '0;
        for (int j = 0; j < S; j++) begin
          if (!cmd_outer)
            acc[j] <= cmd_acc_vec[16*j+:16] & QMASK;
          else
            sCol[j] <= cmd_s_col[SW*j+:SW];
        end
      end
      if (inFire) beatCnt <= beatCnt + LENW'(1);
      if (inFire && !outerMode) begin
        for (int j = 0; j < S; j++) acc[j] <= accNext[j];
      end
      if (inFire && outerMode) begin
        resMat   <= matNext;
        resValid <= 1'b1;
        resLast  <= lastBeat;
      end else if (out_ready) begin
        resValid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/frodo_mac_stream.md
# frodo_mac_stream

Streaming, parametrised successor of the FrodoKEM small-secret multiply-accumulate datapath. It owns a command/data/result valid-ready protocol, a beat counter and a result register, so it sequences a whole row or column pass on its own. Two modes are supported:
- vector mode: out_vec = acc_vec ± Σ_beats s_mat·a
- outer mode: per beat, out_mat = acc_mat ± s_col·a

All arithmetic is modulo 2^LOGQ. The block sits between the matrix-A generator/secret sampler and the result buffer of the FrodoKEM core.

## Interface
- A, 4: a-lanes per beat
- S, 8: rows (secret columns) per pass
- SW, 5: secret code width; bit0 = sign, bits SW-1:1 = unsigned binary magnitude (bit k weighs 2^(k-1))
- LOGQ, 16: modulus exponent, 1..16; every lane is 16-bit aligned and bits 15:LOGQ always read 0
- LENW, 11: beat-count width
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_outer  in  1  0 = vector mode, 1 = outer mode
- cmd_neg  in  1  1 = subtract the products
- cmd_len  in  LENW  number of data beats
- cmd_acc_vec  in  16*S  initial accumulator; lane j at [16j+:16]
- cmd_s_col  in  SW*S  secret column; lane j at [SW*j+:SW]
- in_valid / in_ready  in / out  1  data-beat handshake
- in_a  in  16*A  lane i at [16i+:16]
- in_s_mat  in  SW*A*S  element (j,i) at [SW*(j*A+i)+:SW]
- in_acc_mat  in  16*A*S  element (j,i) at [16*(j*A+i)+:16]
- out_valid / out_ready  out / in  1  result handshake
- out_vec  out  16*S  accumulator (vector-mode result)
- out_mat  out  16*A*S  outer-mode result
- out_last  out  1  marks the final result of a command
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: cmd_ready = 1.
  - RUN: beats accepted.
  - DONE: vector result held.
- Command capture:
  - A cmd handshake captures mode, neg, len and beat_cnt = 0.
  - Vector mode loads acc_vec into the accumulator; outer mode loads s_col.
  - All cmd_* inputs are ignored outside IDLE.
- Transitions:
  - IDLE→RUN on handshake with len ≠ 0.
  - len = 0, vector mode: IDLE→DONE, out_vec = cmd_acc_vec, out_last = 1.
  - len = 0, outer mode: stays IDLE, no result produced.
- Per-element product p = a·mag(s), mod 2^LOGQ.
- Effective sign = s[0] XOR neg; the term is -p when the effective sign is 1, else +p. Negation is two's complement mod 2^LOGQ.
- Vector mode, per accepted beat: acc_j ← acc_j + Σ_i term(s_mat[j][i], a_i), mod 2^LOGQ. On the beat where beat_cnt = len-1: RUN→DONE.
- Outer mode, per accepted beat:
  - Result register ← out_mat[j][i] = acc_mat[j][i] + term(s_col[j], a_i), mod 2^LOGQ.
  - out_last = (beat_cnt = len-1).
  - RUN→IDLE when the out_last result completes its handshake.
- DONE: out_valid = 1, out_vec = accumulator, out_last = 1. Handshake → IDLE.
- out_mat and out_vec are don't-care (held, not cleared) when out_valid = 0.
- Input masking: bits 15:LOGQ of in_a, in_acc_mat and cmd_acc_vec are masked to 0 before use.

## Timing
- Reset (rst = 0, asynchronous):
  - state IDLE; cmd_ready = 1; in_ready = 0; out_valid = 0; out_last = 0; busy = 0.
  - Accumulator, result register and beat_cnt = 0.
  - Asserting reset mid-RUN discards the partial pass with no output.
- cmd_ready = (state = IDLE) combinationally. RUN starts the cycle after the handshake.
- Vector mode:
  - in_ready = (state = RUN).
  - out_valid rises 1 cycle after the last beat is accepted.
  - Throughput: 1 beat per cycle.
- Outer mode:
  - The result register is a single stage with latency 1.
  - in_ready = RUN ∧ beat_cnt < len ∧ (¬out_valid ∨ out_ready).
  - If an out handshake and an in handshake occur in the same cycle, the register reloads and out_valid stays 1.
  - If out_ready = 0, in_ready = 0 and out_valid/out_mat/out_last hold stable.
- Input beats with in_valid = 1 outside RUN are not accepted.
- beat_cnt never exceeds len. A new command is not accepted until the previous one's final result handshake completes.
- No combinational path from in_valid to in_ready. The only combinational path from out_ready to in_ready is the outer-mode term.

## Test plan
- Vector mode, A=4, S=8, LOGQ=16, len=1, acc_vec lanes = 0x0010, all s_mat = 5'b00010 (+1), a = {1,2,3,4}:
  - out_valid 1 cycle after the beat, every out_vec lane = 0x001A, out_last = 1.
  - Repeat with neg = 1: lanes = 0x0006.
  - Repeat with s = 5'b00011 and neg = 1 (signs cancel): lanes = 0x001A.
- LOGQ=15, vector mode, acc = 0x7FFF, s = +1, a = 0x0001 → 0x0000.
  - acc = 0, s = 5'b11111 (-15), a = 1 → 0x7FF1; bit 15 reads 0.
- Outer mode, len=3, s_col lanes = 5'b00100 (+2), acc_mat = 0, a beats = {1,1,1,1}, {2,...}, {3,...}:
  - Results 2, 4, 6; out_last only on the third.
  - Hold out_ready = 0 after the first result: in_ready = 0, out_mat holds 2 until released.
- len=0:
  - Vector mode: out_vec = cmd_acc_vec 1 cycle later, out_last = 1.
  - Outer mode: cmd_ready stays 1, out_valid never rises.
- Vector mode, len=4, rst pulsed low after 2 beats:
  - Immediately IDLE, out_valid = 0, no result.
  - The next command starts from its own acc_vec.
